// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: operand width,
// FSM state encoding and the quotient reported on divide-by-zero.
package div_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div32_seq_if.sv
// Request/result bundle of the divider; the requester drives operands and
// start, the divider returns handshake status and results.
interface div32_seq_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, dbz
  );

endinterface

// File: rtl/div32_seq_sub33.sv
// Structural 33-bit subtractor (a + ~b + 1) built from a ripple of full-adder
// cells; the sign bit of the result tells whether the trial subtraction failed.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sub33
  import div_pkg::*;
(
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH-1:0] diff,
  output logic             neg
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
        .a  (a[i]),
        .b  (~b[i]),
        .ci (carry[i]),
        .s  (diff[i]),
        .co (carry[i+1])
      );
    end
  endgenerate

  // Only the sum of the top bit is needed: it is the sign of the trial result.
  assign neg = a[WIDTH] ^ ~b[WIDTH] ^ carry[WIDTH];
endmodule

// File: rtl/div32_seq.sv
// Iterative 32-bit unsigned restoring divider: one trial subtraction per clock,
// results and divide-by-zero flag held from the done pulse until the next done.
module div32_seq
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  div32_seq_if.slave  bus
);
  state_t           state_r;
  state_t           next_state_s;
  logic [4:0]       count_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_pend_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic             accept_s;
  logic             finish_s;
  logic             neg_s;
  logic             zero_div_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] q_next_s;

  assign zero_div_s = (bus.divisor == {WIDTH{1'b0}});

  sub33 u_sub (
    .a    (trial_s),
    .b    ({1'b0, dsr_r}),
    .diff (diff_s),
    .neg  (neg_s)
  );

  // Next-state decode: IDLE and DONE both accept a new request.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept_s     = 1'b1;
          next_state_s = S_RUN;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (count_r == 5'd31) begin
          finish_s     = 1'b1;
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit and keep the difference if it did not go negative.
  always_comb begin
    trial_s = {rem_r, dvd_r[WIDTH-1]};
    if (neg_s) begin
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      rem_next_s = diff_s;
    end
    q_next_s = {q_r[WIDTH-2:0], ~neg_s};
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s != S_RUN);
      busy_r  <= (next_state_s == S_RUN);
      done_r  <= (next_state_s == S_DONE);
    end
  end

  // Operand latch and shift datapath; a zero divisor runs a single pass-through step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_r      <= {WIDTH{1'b0}};
      dsr_r      <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      q_r        <= {WIDTH{1'b0}};
      count_r    <= 5'd0;
      dbz_pend_r <= 1'b0;
    end else if (accept_s) begin
      dvd_r      <= bus.dividend;
      dsr_r      <= bus.divisor;
      rem_r      <= {WIDTH{1'b0}};
      q_r        <= {WIDTH{1'b0}};
      count_r    <= zero_div_s ? 5'd31 : 5'd0;
      dbz_pend_r <= zero_div_s;
    end else if (state_r == S_RUN) begin
      dvd_r   <= {dvd_r[WIDTH-2:0], 1'b0};
      rem_r   <= rem_next_s;
      q_r     <= q_next_s;
      count_r <= count_r + 5'd1;
    end
  end

  // Results and dbz change only on entry to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else if (finish_s) begin
      if (dbz_pend_r) begin
        quotient_r  <= DBZ_QUOTIENT;
        remainder_r <= dvd_r;
        dbz_r       <= 1'b1;
      end else begin
        quotient_r  <= q_next_s;
        remainder_r <= rem_next_s;
        dbz_r       <= 1'b0;
      end
    end
  end

  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.dbz       = dbz_r;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases plus randomized
// operands compared against a plain-arithmetic reference model.
module tb_div32_seq;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass = 0;

  div32_seq_if bus ();

  div32_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic wait_done(inout int n);
    while (bus.done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ez;
    logic [63:0] recon;
    model(a, b, eq, er, ez);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_quot"}, bus.quotient, eq);
    check({tag, "_rem"}, bus.remainder, er);
    check({tag, "_dbz"}, {31'd0, bus.dbz}, {31'd0, ez});
    if (!ez) begin
      recon = 64'(bus.quotient) * 64'(b) + 64'(bus.remainder);
      check({tag, "_inv_eq"}, {31'd0, recon == 64'(a)}, 32'd1);
      check({tag, "_inv_lt"}, {31'd0, bus.remainder < b}, 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit chk_lat);
    int n = 0;
    wait_ready();
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    step();
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    wait_done(n);
    if (chk_lat) check({tag, "_latency"}, 32'(n), (b == 32'd0) ? 32'd1 : 32'd32);
    check_result(tag, a, b);
    step();
    check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    int n, m, sel;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
    #12;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_quot", bus.quotient, 32'd0);
    check("rst_rem", bus.remainder, 32'd0);
    check("rst_dbz", {31'd0, bus.dbz}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    step();

    run_op("d100_7", 32'd100, 32'd7, 1'b1);
    check("d100_7_q_const", bus.quotient, 32'd14);
    check("d100_7_r_const", bus.remainder, 32'd2);
    run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op("d3_10", 32'd3, 32'd10, 1'b1);

    // Start pulse mid-run is ignored; start held through done chains a second op.
    wait_ready();
    bus.start = 1'b1; bus.dividend = 32'd123456789; bus.divisor = 32'd1000;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd0;
    step();
    bus.start = 1'b0;
    n = 11;
    while (bus.done !== 1'b1 && n < 200) begin
      if (n == 20) begin
        bus.start = 1'b1; bus.dividend = 32'd4000000000; bus.divisor = 32'd7;
      end
      step();
      n++;
    end
    check("ign_latency", 32'(n), 32'd32);
    check_result("ign", 32'd123456789, 32'd1000);
    step();
    bus.start = 1'b0;
    m = 1;
    wait_done(m);
    check("b2b_spacing", 32'(m), 32'd33);
    check_result("b2b", 32'd4000000000, 32'd7);
    step();

    run_op("d5_0", 32'd5, 32'd0, 1'b1);

    // Asynchronous reset in the middle of a run clears everything at once.
    wait_ready();
    bus.start = 1'b1; bus.dividend = 32'hDEAD_BEEF; bus.divisor = 32'd3;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_quot", bus.quotient, 32'd0);
    check("mid_rst_rem", bus.remainder, 32'd0);
    check("mid_rst_dbz", {31'd0, bus.dbz}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    step();
    run_op("d1000_33", 32'd1000, 32'd33, 1'b1);
    check("d1000_33_q_const", bus.quotient, 32'd30);
    check("d1000_33_r_const", bus.remainder, 32'd10);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: b = a;
        1: b = a + 32'($urandom_range(1, 1000));
        2: begin
          a = a >> $urandom_range(0, 24);
          b = 32'($urandom_range(1, 255));
        end
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op("rand", a, b, (i % 50) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
